// File: rtl/pe_row_feeder.sv
// -----------------------------------------------------------------------------
// pe_row_feeder
//
// Operand skew feeder for the west edge of the PE array. One column vector of
// ROWS operands is accepted per handshake; lane r is delayed by r array steps
// so the systolic wavefront lines up across rows. A programmed tile length is
// counted, the skew pipeline is flushed with bubbles, and a one-cycle done
// pulse marks the end of the tile.
//
// Ports
//   clk       clock, all state on the rising edge
//   rst       asynchronous active-low reset
//   start     begin a tile (sampled only when idle)
//   k_len     vectors per tile, latched on an accepted start
//   in_valid  in_data holds a vector
//   in_ready  vector accepted this cycle when in_valid is also high
//   in_data   lane r at bits [r*DATA_W +: DATA_W]
//   advance   array steps this cycle and captures out_*
//   out_data  per-row operand, forced to zero when the row's enable is low
//   out_en    per-row input enable
//   busy      high while feeding or draining
//   done      one-cycle pulse at tile end
// -----------------------------------------------------------------------------
module pe_row_feeder #(
  parameter int DATA_W = 16,
  parameter int ROWS   = 4,
  parameter int K_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [K_W-1:0]         k_len,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ROWS*DATA_W-1:0] in_data,
  input  logic                   advance,
  output logic [ROWS*DATA_W-1:0] out_data,
  output logic [ROWS-1:0]        out_en,
  output logic                   busy,
  output logic                   done
);

  localparam int                DRN_W    = $clog2(ROWS + 1);
  localparam logic [DRN_W-1:0]  DRN_LAST = DRN_W'(ROWS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [K_W-1:0]   r_k;
  logic [K_W-1:0]   r_cnt;
  logic [K_W-1:0]   w_cnt_inc;
  logic [DRN_W-1:0] r_drn;
  logic             w_accept;
  logic             w_step;

  assign w_cnt_inc = r_cnt + K_W'(1);
  assign w_accept  = in_valid & in_ready;
  // The skew pipeline only moves when the array steps during an active tile.
  assign w_step    = advance & busy;

  // FSM: state and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_cnt   <= '0;
      r_drn   <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_k   <= k_len;
            r_cnt <= '0;
            r_drn <= '0;
          end
        end
        S_FEED: begin
          if (w_accept) r_cnt <= w_cnt_inc;
        end
        S_DRAIN: begin
          if (advance) r_drn <= r_drn + DRN_W'(1);
        end
        default: ;
      endcase
    end
  end

  // FSM: next state and control outputs
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = (k_len == '0) ? S_DONE : S_FEED;
      end
      S_FEED: begin
        busy     = 1'b1;
        // A vector is taken only when the array steps, so a stall never
        // loses or duplicates an operand.
        in_ready = advance;
        // Exact compare: the count never has to wrap for a 2^K_W-1 tile.
        if (in_valid && advance && (w_cnt_inc == r_k)) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        // ROWS bubble steps push the deepest lane's last operand out.
        if (advance && (r_drn == DRN_LAST)) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Skew pipeline: lane g is a g-stage delay line followed by its output
  // register (index g). Lane 0 gets a bubble on any step without an accept,
  // which also covers every step taken while draining.
  for (genvar g = 0; g < ROWS; g++) begin : g_lane
    logic [DATA_W-1:0] r_dat [0:g];
    logic [g:0]        r_en;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_en <= '0;
      end else if (w_step) begin
        r_en[0] <= w_accept;
        for (int s = 1; s <= g; s++) r_en[s] <= r_en[s-1];
      end
    end

    // Data stages carry no reset; the enable bit masks any stale value.
    always_ff @(posedge clk) begin
      if (w_step) begin
        r_dat[0] <= in_data[g*DATA_W +: DATA_W];
        for (int s = 1; s <= g; s++) r_dat[s] <= r_dat[s-1];
      end
    end

    assign out_en[g]                    = r_en[g];
    assign out_data[g*DATA_W +: DATA_W] = r_en[g] ? r_dat[g] : '0;
  end

endmodule

// File: tb/tb_pe_row_feeder.sv
// -----------------------------------------------------------------------------
// tb_pe_row_feeder
//
// Randomised bench for pe_row_feeder. The driver steps through each tile and
// records the sequence of lane-0 slots the array should see (one per array
// step: a vector or a bubble). Lane r of the array must capture that same
// slot sequence delayed by r+1 steps, so for each step the driver pushes the
// expected full column into a queue; an independent monitor pops one column
// every time the array captures during a busy cycle and compares it.
// Control outputs (busy, done, in_ready) are compared cycle by cycle against
// the tile-level counts of accepted vectors and drain steps.
// -----------------------------------------------------------------------------
module tb_pe_row_feeder;

  localparam int DATA_W = 16;
  localparam int ROWS   = 4;
  localparam int K_W    = 8;
  localparam int VW     = ROWS * DATA_W;

  typedef struct packed {
    logic [ROWS-1:0] en;
    logic [VW-1:0]   dat;
  } col_t;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                start = 1'b0;
  logic [K_W-1:0]      k_len = '0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [VW-1:0]       in_data = '0;
  logic                advance = 1'b0;
  logic [VW-1:0]       out_data;
  logic [ROWS-1:0]     out_en;
  logic                busy;
  logic                done;

  int   n_chk  = 0;
  int   n_pass = 0;
  col_t exp_q[$];

  always #5 clk = ~clk;

  pe_row_feeder #(.DATA_W(DATA_W), .ROWS(ROWS), .K_W(K_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .k_len    (k_len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .advance  (advance),
    .out_data (out_data),
    .out_en   (out_en),
    .busy     (busy),
    .done     (done)
  );

  task automatic chkw(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chkw(nm, 128'(act), 128'(exp));
  endtask

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int r = 0; r < ROWS; r++) v[r*DATA_W +: DATA_W] = DATA_W'($urandom);
    return v;
  endfunction

  // Monitor: scoreboard pops, zero-masking, idle-quiet and stall-hold rules.
  logic [ROWS-1:0] prv_en;
  logic [VW-1:0]   prv_dat;
  logic            prv_adv;
  bit              prv_ok = 1'b0;
  col_t            mon_e;

  always @(negedge clk) begin
    if (!rst) begin
      prv_ok = 1'b0;
    end else begin
      if (busy && advance) begin
        if (exp_q.size() == 0) begin
          chkw("capture_unexpected", 128'({out_en, out_data}), 128'(0));
        end else begin
          mon_e = exp_q.pop_front();
          chkw("capture_column", 128'({out_en, out_data}), 128'(mon_e));
        end
      end
      for (int r = 0; r < ROWS; r++)
        if (!out_en[r]) chkw("bubble_zero", 128'(out_data[r*DATA_W +: DATA_W]), 128'(0));
      if (!busy) chkw("idle_out_en", 128'(out_en), 128'(0));
      if (prv_ok && !prv_adv) begin
        chkw("stall_hold_en", 128'(out_en), 128'(prv_en));
        chkw("stall_hold_data", 128'(out_data), 128'(prv_dat));
      end
      prv_en  = out_en;
      prv_dat = out_data;
      prv_adv = advance;
      prv_ok  = 1'b1;
    end
  end

  // One tile of k vectors. adv_pct / val_pct set the probability of advance
  // and in_valid per cycle. abort_at > 0 resets the block once that many
  // vectors have been accepted (use with full throughput).
  task automatic run_tile(input int k, input int adv_pct, input int val_pct, input int abort_at);
    int            acc;
    int            dadv;
    bit            adv, val, feed, drain, fin, ended;
    logic [VW-1:0] vec;
    logic [VW-1:0] hist_v[$];
    bit            hist_e[$];
    col_t          c;

    // Start cycle, block idle.
    @(posedge clk); #1;
    start    = 1'b1;
    k_len    = K_W'(k);
    advance  = ($urandom_range(1, 100) <= adv_pct);
    in_valid = $urandom_range(0, 1);
    in_data  = rand_vec();
    for (int r = 0; r < ROWS; r++) begin
      hist_v.push_back('0);
      hist_e.push_back(1'b0);
    end
    exp_q.push_back('0);
    @(negedge clk);
    chk1("start_busy", busy, 1'b0);
    chk1("start_done", done, 1'b0);
    chk1("start_in_ready", in_ready, 1'b0);

    acc   = 0;
    dadv  = 0;
    ended = 1'b0;
    for (int cyc = 0; cyc < 3000 && !ended; cyc++) begin
      @(posedge clk); #1;
      // start and k_len outside idle must have no effect.
      start    = $urandom_range(0, 1);
      k_len    = K_W'($urandom);
      adv      = ($urandom_range(1, 100) <= adv_pct);
      val      = ($urandom_range(1, 100) <= val_pct);
      vec      = rand_vec();
      advance  = adv;
      in_valid = val;
      in_data  = vec;
      feed  = (acc < k);
      drain = !feed && (dadv < ROWS);
      fin   = !feed && !drain;

      if (abort_at > 0 && feed && acc == abort_at) begin
        chkw("pre_abort_out_en", 128'(out_en), 128'({ROWS{1'b1}}));
        rst = 1'b0;
        #1;
        chkw("abort_out_en", 128'(out_en), 128'(0));
        chkw("abort_out_data", 128'(out_data), 128'(0));
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_done", done, 1'b0);
        chk1("abort_in_ready", in_ready, 1'b0);
        exp_q.delete();
        @(negedge clk);
        @(posedge clk); #1;
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b1;
        advance  = 1'b1;
        @(negedge clk);
        chk1("post_abort_busy", busy, 1'b0);
        chk1("post_abort_done", done, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk1("post_abort_idle", busy, 1'b0);
        return;
      end

      @(negedge clk);
      chk1("busy", busy, feed | drain);
      chk1("done", done, fin);
      chk1("in_ready", in_ready, feed & adv);
      if (fin) begin
        chkw("leftover_columns", 128'(exp_q.size()), 128'(1));
        exp_q.delete();
        ended = 1'b1;
      end else if (adv) begin
        if (feed && val) acc++;
        if (drain) dadv++;
        hist_e.push_back(feed && val);
        hist_v.push_back((feed && val) ? vec : '0);
        c = '0;
        for (int r = 0; r < ROWS; r++) begin
          int idx;
          idx = hist_e.size() - 1 - r;
          c.en[r] = hist_e[idx];
          c.dat[r*DATA_W +: DATA_W] = hist_v[idx][r*DATA_W +: DATA_W];
        end
        exp_q.push_back(c);
      end
    end
    if (!ended) begin
      chk1("tile_timeout", 1'b0, 1'b1);
      exp_q.delete();
    end
  endtask

  // Zero-length tile: done the cycle after start, nothing fed.
  task automatic run_zero();
    @(posedge clk); #1;
    start    = 1'b1;
    k_len    = '0;
    advance  = 1'b1;
    in_valid = 1'b1;
    in_data  = rand_vec();
    @(negedge clk);
    chk1("k0_start_done", done, 1'b0);
    chk1("k0_start_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk1("k0_done", done, 1'b1);
    chk1("k0_busy", busy, 1'b0);
    chk1("k0_in_ready", in_ready, 1'b0);
    chkw("k0_out_en", 128'(out_en), 128'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk1("k0_done_once", done, 1'b0);
    chk1("k0_in_ready_after", in_ready, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chkw("rst_out_en", 128'(out_en), 128'(0));
    chkw("rst_out_data", 128'(out_data), 128'(0));
    @(posedge clk); #1;
    rst = 1'b1;

    run_tile(3, 100, 100, 0);
    run_tile(2, 100, 60, 0);
    run_tile(4, 60, 100, 0);
    run_zero();
    run_tile(1, 100, 100, 0);
    run_tile(8, 100, 100, 6);
    run_tile(3, 100, 100, 0);
    for (int i = 0; i < 40; i++)
      run_tile($urandom_range(1, 12), $urandom_range(30, 100), $urandom_range(30, 100), 0);
    run_zero();
    run_tile(255, 100, 90, 0);
    run_tile(1, 50, 50, 0);

    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b0;
    advance  = 1'b0;
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
